// File: rtl/if_stage_pkg.sv
// Shared pipeline definitions for the fetch stage: FSM state codes, NOP encoding,
// PC step and opcode field bounds consumed by the ID-stage decoder.
package if_stage_pkg;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;
    localparam int          OPC_HI    = 31;
    localparam int          OPC_LO    = 26;

    // 32-bit sequential increment; wraps past 32'hFFFF_FFFC silently
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a NOP bubble.
// Latency 1 cycle; no backpressure of its own, hold comes from the hazard unit.
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_hold,
    input  logic               i_load,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [31:0]        i_pc,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [31:0]        o_pc
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_instr <= INSTR_W'(NOP_INSTR);
            o_pc    <= 32'h0;
        end else if (i_flush) begin
            o_valid <= 1'b0;
            o_instr <= INSTR_W'(NOP_INSTR);
            o_pc    <= 32'h0;
        end else if (i_hold) begin
            o_valid <= o_valid;
            o_instr <= o_instr;
            o_pc    <= o_pc;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_instr <= i_instr;
            o_pc    <= i_pc;
        end else begin
            o_valid <= 1'b0;
            o_instr <= INSTR_W'(NOP_INSTR);
            o_pc    <= 32'h0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, one-outstanding imem fetch FSM, hold buffer, IF/ID register.
// Request is combinational from state; IF/ID updates one cycle after the response.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          INSTR_W  = 32
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_freeze,
    input  logic               i_br_taken,
    input  logic [31:0]        i_br_addr,
    output logic               o_imem_req,
    output logic [31:0]        o_imem_addr,
    input  logic               i_imem_rvalid,
    input  logic [INSTR_W-1:0] i_imem_rdata,
    output logic               o_if_id_valid,
    output logic [INSTR_W-1:0] o_if_id_instr,
    output logic [31:0]        o_if_id_pc
);

    logic [1:0]         r_state;
    logic [31:0]        r_pc;
    logic [31:0]        r_inflight_pc;
    logic [INSTR_W-1:0] r_hold_instr;
    logic [31:0]        r_hold_pc;

    logic               w_load_wait;
    logic               w_load_hold;
    logic [INSTR_W-1:0] w_instr;
    logic [31:0]        w_pc;

    // A redirect in S_REQ suppresses the fetch so the new target is fetched next cycle
    assign o_imem_req  = (r_state == S_REQ) && !i_br_taken;
    assign o_imem_addr = r_pc;

    assign w_load_wait = (r_state == S_WAIT) && i_imem_rvalid && !i_br_taken && !i_freeze;
    assign w_load_hold = (r_state == S_HOLD) && !i_br_taken && !i_freeze;
    assign w_instr     = w_load_hold ? r_hold_instr : i_imem_rdata;
    assign w_pc        = w_load_hold ? r_hold_pc : pc_inc(r_inflight_pc);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_inflight_pc <= 32'h0;
            r_hold_instr  <= '0;
            r_hold_pc     <= 32'h0;
        end else begin
            case (r_state)
                S_REQ: begin
                    if (i_br_taken) begin
                        r_pc <= i_br_addr;
                    end else begin
                        r_inflight_pc <= r_pc;
                        r_pc          <= pc_inc(r_pc);
                        r_state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (i_br_taken) begin
                            r_pc    <= i_br_addr;
                            r_state <= S_REQ;
                        end else if (!i_freeze) begin
                            r_state <= S_REQ;
                        end else begin
                            r_hold_instr <= i_imem_rdata;
                            r_hold_pc    <= pc_inc(r_inflight_pc);
                            r_state      <= S_HOLD;
                        end
                    end else if (i_br_taken) begin
                        // Response still owed by memory; it must be swallowed later
                        r_pc    <= i_br_addr;
                        r_state <= S_DROP;
                    end
                end
                S_HOLD: begin
                    if (i_br_taken) begin
                        r_pc    <= i_br_addr;
                        r_state <= S_REQ;
                    end else if (!i_freeze) begin
                        r_state <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (i_br_taken) begin
                        r_pc <= i_br_addr;
                    end
                    if (i_imem_rvalid) begin
                        r_state <= S_REQ;
                    end
                end
                default: r_state <= S_REQ;
            endcase
        end
    end

    if_id_reg #(
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_br_taken),
        .i_hold  (i_freeze),
        .i_load  (w_load_wait || w_load_hold),
        .i_instr (w_instr),
        .i_pc    (w_pc),
        .o_valid (o_if_id_valid),
        .o_instr (o_if_id_instr),
        .o_pc    (o_if_id_pc)
    );

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage: architectural fetch-stream model with a scoreboard
// filled at request time and drained by a monitor watching the IF/ID register.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_freeze;
    logic        i_br_taken;
    logic [31:0] i_br_addr;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_if_id_valid;
    logic [31:0] o_if_id_instr;
    logic [31:0] o_if_id_pc;

    if_stage #(
        .RESET_PC (RESET_PC),
        .INSTR_W  (32)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_freeze      (i_freeze),
        .i_br_taken    (i_br_taken),
        .i_br_addr     (i_br_addr),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_if_id_valid (o_if_id_valid),
        .o_if_id_instr (o_if_id_instr),
        .o_if_id_pc    (o_if_id_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          errs = 0;
    int          checks = 0;
    int          deliveries = 0;
    logic        mon_en = 1'b0;
    logic        cyc_br = 1'b0;
    logic        cyc_frz = 1'b0;
    logic [31:0] exp_next;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [31:0] m_pc = 32'h0;
    exp_t        e;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5C3_0000;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle of stimulus, called right after a falling edge
    task automatic step_body(input bit quiet);
        i_imem_rvalid = 1'b0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                i_imem_rvalid = 1'b1;
                i_imem_rdata  = mem_word(mem_addr);
                mem_pend      = 1'b0;
            end
        end
        i_freeze   = !quiet && ($urandom_range(0, 3) == 0);
        i_br_taken = !quiet && ($urandom_range(0, 12) == 0);
        if (i_br_taken) begin
            case ($urandom_range(0, 3))
                0:       i_br_addr = 32'hFFFF_FFFC;
                1:       i_br_addr = 32'hFFFF_FFF8;
                default: i_br_addr = $urandom & 32'h0000_FFFC;
            endcase
            // A redirect kills everything requested but not yet in IF/ID
            exp_next = i_br_addr;
            sb.delete();
        end
        cyc_br  = i_br_taken;
        cyc_frz = i_freeze;
        #1;
        if (o_imem_req) begin
            chk("req_addr", o_imem_addr, exp_next);
            chk("one_outstanding", {31'b0, mem_pend || i_imem_rvalid}, 32'h0);
            mem_pend = 1'b1;
            mem_cnt  = $urandom_range(1, 3);
            mem_addr = o_imem_addr;
            sb.push_back({mem_word(o_imem_addr), o_imem_addr + 32'd4});
            exp_next = o_imem_addr + 32'd4;
        end
    endtask

    // Monitor: expected IF/ID content follows flush / hold / deliver-or-bubble
    always @(posedge i_clk) begin
        #1;
        if (mon_en) begin
            if (cyc_br) begin
                m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
            end else if (!cyc_frz) begin
                if (o_if_id_valid) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errs++;
                        $display("FAIL unexpected_delivery: got pc %h expected none at %0t", o_if_id_pc, $time);
                        m_valid = 1'b1; m_instr = o_if_id_instr; m_pc = o_if_id_pc;
                    end else begin
                        e = sb.pop_front();
                        deliveries++;
                        m_valid = 1'b1; m_instr = e.instr; m_pc = e.pc;
                    end
                end else begin
                    m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
                end
            end
            chk("if_id_valid", {31'b0, o_if_id_valid}, {31'b0, m_valid});
            chk("if_id_instr", o_if_id_instr, m_instr);
            if (m_valid) chk("if_id_pc", o_if_id_pc, m_pc);
        end
    end

    initial begin
        bit found;
        i_rst_n       = 1'b0;
        i_freeze      = 1'b0;
        i_br_taken    = 1'b0;
        i_br_addr     = 32'h0;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        exp_next      = RESET_PC;

        repeat (3) @(negedge i_clk);
        #1;
        chk("rst_valid", {31'b0, o_if_id_valid}, 32'h0);
        chk("rst_instr", o_if_id_instr, 32'h0);
        chk("rst_pc", o_if_id_pc, 32'h0);
        chk("rst_req", {31'b0, o_imem_req}, 32'h1);
        chk("rst_addr", o_imem_addr, RESET_PC);

        @(negedge i_clk);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;
        step_body(1'b0);
        repeat (1500) begin
            @(negedge i_clk);
            step_body(1'b0);
        end

        // Reset while a fetch is outstanding with its response still two or more cycles away
        found = 1'b0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge i_clk);
            if (mem_pend && mem_cnt >= 2) found = 1'b1;
            else step_body(1'b0);
        end
        chk("reach_wait", {31'b0, found}, 32'h1);
        mon_en        = 1'b0;
        i_rst_n       = 1'b0;
        i_imem_rvalid = 1'b0;
        i_freeze      = 1'b0;
        i_br_taken    = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, o_if_id_valid}, 32'h0);
        chk("midrst_instr", o_if_id_instr, 32'h0);
        chk("midrst_pc", o_if_id_pc, 32'h0);
        mem_pend = 1'b0;
        sb.delete();
        exp_next = RESET_PC;
        m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        mon_en  = 1'b1;
        step_body(1'b0);
        repeat (1500) begin
            @(negedge i_clk);
            step_body(1'b0);
        end

        repeat (20) begin
            @(negedge i_clk);
            step_body(1'b1);
        end
        @(negedge i_clk);
        chk("drain_backlog", {31'b0, sb.size() <= 1}, 32'h1);
        chk("progress", {31'b0, deliveries >= 200}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipeline, directly upstream of the ID-stage decoder/controller. Holds the PC, issues one-outstanding fetches to instruction memory, and drives the IF/ID pipeline register whose `if_id_instr[31:26]` is the opcode the decoder consumes. Handles freeze (stall) from the hazard unit and taken-branch/jump redirects from EXE, including discarding a stale in-flight response.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `INSTR_W`, 32, instruction width (opcode in bits [31:26])
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `freeze`  in  1  hazard unit: hold IF/ID and fetch progress
- `br_taken`  in  1  EXE: redirect PC this cycle (priority over freeze)
- `br_addr`  in  32  redirect target
- `imem_req`  out  1  single-cycle fetch request
- `imem_addr`  out  32  fetch address, valid with `imem_req`
- `imem_rvalid`  in  1  response strobe, ≥1 cycle after request
- `imem_rdata`  in  INSTR_W  fetched instruction
- `if_id_valid`  out  1  IF/ID holds a live instruction
- `if_id_instr`  out  INSTR_W  instruction to ID
- `if_id_pc`  out  32  address of that instruction + 4

## Operation
- Registers: `pc` (next fetch address), `inflight_pc`, hold buffer (`hold_instr`, `hold_pc`), IF/ID register, state.
- States: S_REQ, S_WAIT, S_HOLD, S_DROP. Reset state S_REQ.
- S_REQ: `imem_req`=1, `imem_addr`=`pc` unless `br_taken` (then `imem_req`=0, `pc`<=`br_addr`, stay). On issue: `inflight_pc`<=`pc`, `pc`<=`pc`+4, -> S_WAIT. Freeze does not suppress issue.
- S_WAIT, `imem_rvalid`=1: `br_taken` -> response dropped, `pc`<=`br_addr`, -> S_REQ. Else `freeze`=0 -> IF/ID loads {1, `imem_rdata`, `inflight_pc`+4}, -> S_REQ. Else (`freeze`=1) -> hold buffer loads response, -> S_HOLD.
- S_WAIT, no `imem_rvalid`: `br_taken` -> `pc`<=`br_addr`, -> S_DROP; else stay.
- S_HOLD: `br_taken` -> hold buffer discarded, `pc`<=`br_addr`, -> S_REQ. Else `freeze`=0 -> IF/ID loads hold buffer, -> S_REQ. Else stay.
- S_DROP: next `imem_rvalid` discarded, -> S_REQ. `br_taken` here updates `pc` again, stays S_DROP.
- IF/ID update rule each edge: `br_taken`=1 -> flush (valid 0, instr 0, pc 0). Else `freeze`=1 -> hold. Else load new instruction if delivered this cycle, otherwise bubble (valid 0, instr 0 = NOP).
- PC arithmetic: 32-bit, +4, wraps 32'hFFFF_FFFC -> 0 silently. `br_addr` used as-is (no alignment check).

## Timing
- Reset values: `pc`=RESET_PC, state S_REQ, `if_id_valid`=0, `if_id_instr`=0, `if_id_pc`=0, hold buffer 0. `imem_req`=1 in first cycle after reset release (combinational from state, gated by `br_taken`).
- Fetch latency: request cycle t, response cycle t+k (k≥1), instruction visible on IF/ID at t+k+1; next request at t+k+1. Throughput one instruction per k+1 cycles.
- `imem_addr`/`imem_req` combinational from state and `pc`; all other outputs registered.
- Simultaneous `br_taken` and `freeze`: branch wins everywhere.
- Reset mid-fetch: state/pc/IF/ID cleared immediately; instruction memory shares `rst_n` and must abort its request, so no stale response after reset.
- `imem_rvalid` in S_REQ or S_HOLD is a protocol error; ignored.

## Structure
- Shared pipeline package: state enum, `NOP_INSTR`=32'h0, `PC_STEP`=4, opcode field bounds [31:26].
- One sub-module `if_id_reg`: IF/ID register with load/hold/flush controls; fetch FSM, PC and hold buffer stay in `if_stage`.

## Test plan
- Reset release, memory k=1 returning 32'h0400_0000 then 32'h0C00_0000 -> `imem_addr` 0, 4; IF/ID {1, 32'h0400_0000, 4} then {1, 32'h0C00_0000, 8}, valid 0 in between.
- `freeze` high 3 cycles spanning a response at `pc` 8 -> S_HOLD, IF/ID unchanged, no new request; after release IF/ID shows `if_id_pc`=12, next `imem_addr`=12.
- k=3, `br_taken` with `br_addr`=32'h40 one cycle after request -> S_DROP, stale response not loaded, next `imem_addr`=32'h40, IF/ID flushed.
- `br_taken` and `freeze` together in S_HOLD -> hold discarded, IF/ID flushed, next `imem_addr`=`br_addr`.
- `rst_n` asserted during S_WAIT -> outputs at reset values within same cycle, first request after release at RESET_PC.
- `pc`=32'hFFFF_FFFC fetch -> `if_id_pc`=0, next `imem_addr`=0.
